// File: rtl/branch_history_table_pkg.sv
// Shared encodings and defaults for the branch history table direction predictor.
package branch_history_table_pkg;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam int unsigned BHT_MODE_BIMODAL = 0;
  localparam int unsigned BHT_MODE_GSHARE  = 1;

  localparam int unsigned DEF_IDX_W  = 6;
  localparam int unsigned DEF_HIST_W = 6;

endpackage

// File: rtl/bht_sat_cnt.sv
// 2-bit saturating counter next-state function used on the table update path.
module bht_sat_cnt
  import branch_history_table_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    case (cnt)
      CNT_SNT: cnt_next = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: cnt_next = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  cnt_next = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  cnt_next = taken ? CNT_ST  : CNT_WT;
    endcase
  end

endmodule

// File: rtl/branch_history_table.sv
// Dual-lookup bimodal/gshare direction predictor with one resolve-time update
// per cycle and saturating branch/mispredict statistics.
module branch_history_table
  import branch_history_table_pkg::*;
#(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned IDX_W    = DEF_IDX_W,
  parameter int unsigned HIST_W   = DEF_HIST_W,
  parameter int unsigned MODE     = BHT_MODE_BIMODAL,
  parameter logic [1:0]  INIT_CNT = CNT_WNT,
  parameter int unsigned STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   lk0_pc,
  input  logic [PC_W-1:0]   lk1_pc,
  output logic              lk0_taken,
  output logic              lk1_taken,
  output logic [IDX_W-1:0]  lk0_idx,
  output logic [IDX_W-1:0]  lk1_idx,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic              upd_mispredict,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [1:0]        table_q [DEPTH];
  logic [1:0]        table_d [DEPTH];
  logic [HIST_W-1:0] ghr_q, ghr_d, ghr_shift;
  logic [STAT_W-1:0] stat_br_q, stat_br_d;
  logic [STAT_W-1:0] stat_mp_q, stat_mp_d;
  logic [1:0]        upd_cnt_next;
  logic [IDX_W-1:0]  hist_mask;
  logic              unused_pc_bits;

  // Only pc[IDX_W+1:2] feeds the index; the remaining PC bits are intentionally ignored.
  assign unused_pc_bits = ^{lk0_pc, lk1_pc};

  assign hist_mask = (MODE == BHT_MODE_GSHARE) ? IDX_W'(ghr_q) : '0;
  assign lk0_idx   = lk0_pc[IDX_W+1:2] ^ hist_mask;
  assign lk1_idx   = lk1_pc[IDX_W+1:2] ^ hist_mask;
  assign lk0_taken = table_q[lk0_idx][1];
  assign lk1_taken = table_q[lk1_idx][1];

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

  bht_sat_cnt u_sat_cnt (
    .cnt      (table_q[upd_idx]),
    .taken    (upd_taken),
    .cnt_next (upd_cnt_next)
  );

  generate
    if (HIST_W == 1) begin : g_hist_one
      assign ghr_shift = upd_taken;
    end else begin : g_hist_multi
      assign ghr_shift = {ghr_q[HIST_W-2:0], upd_taken};
    end
  endgenerate

  // Next-state for table, history and statistics; clear beats increment.
  always_comb begin
    table_d   = table_q;
    ghr_d     = ghr_q;
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (upd_valid) begin
      table_d[upd_idx] = upd_cnt_next;
      ghr_d            = ghr_shift;
      if (stat_br_q != STAT_MAX) begin
        stat_br_d = stat_br_q + STAT_W'(1);
      end
      if (upd_mispredict && (stat_mp_q != STAT_MAX)) begin
        stat_mp_d = stat_mp_q + STAT_W'(1);
      end
    end
    if (stat_clr) begin
      stat_br_d = '0;
      stat_mp_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      table_q   <= '{default: INIT_CNT};
      ghr_q     <= '0;
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      table_q   <= table_d;
      ghr_q     <= ghr_d;
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

endmodule

// File: tb/tb_branch_history_table.sv
// Bench for branch_history_table: bimodal, gshare and narrow-statistics instances
// driven in lockstep from a vector table, checked against a queued reference model.
module tb_branch_history_table;

  typedef struct {
    logic        rst, uv;
    logic [5:0]  ui;
    logic        ut, um, sc;
    logic [31:0] pc0;
    logic        hchk;
    int          hsel;
    logic        htk0;
    logic [5:0]  hidx0, hidx1;
    logic [31:0] hsb, hsm;
  } vec_t;

  typedef struct {
    logic             mval;
    logic [2:0]       tk0, tk1;
    logic [2:0][5:0]  idx0, idx1;
    logic [2:0][31:0] sb, sm;
    logic             hchk;
    int               hsel;
    logic             htk0;
    logic [5:0]       hidx0, hidx1;
    logic [31:0]      hsb, hsm;
  } exp_t;

  localparam logic [31:0] PC1 = 32'h104;

  logic        clk;
  logic        rst;
  logic [31:0] lk0_pc, lk1_pc;
  logic        upd_valid, upd_taken, upd_mispredict, stat_clr;
  logic [5:0]  upd_idx;

  logic        o_tk0  [3];
  logic        o_tk1  [3];
  logic [5:0]  o_idx0 [3];
  logic [5:0]  o_idx1 [3];
  logic [31:0] o_sb   [3];
  logic [31:0] o_sm   [3];
  logic [31:0] w_sb0, w_sm0, w_sb1, w_sm1;
  logic [3:0]  w_sb2, w_sm2;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks;
  int   errors;

  logic [1:0]  mtab [3][64];
  logic [5:0]  mghr [3];
  logic [31:0] msb  [3];
  logic [31:0] msm  [3];
  bit          mvalid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  branch_history_table #(.MODE(0), .STAT_W(32)) dut_bi (
    .clk(clk), .rst(rst), .lk0_pc(lk0_pc), .lk1_pc(lk1_pc),
    .lk0_taken(o_tk0[0]), .lk1_taken(o_tk1[0]), .lk0_idx(o_idx0[0]), .lk1_idx(o_idx1[0]),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .stat_clr(stat_clr),
    .stat_branches(w_sb0), .stat_mispredicts(w_sm0)
  );

  branch_history_table #(.MODE(1), .STAT_W(32)) dut_gs (
    .clk(clk), .rst(rst), .lk0_pc(lk0_pc), .lk1_pc(lk1_pc),
    .lk0_taken(o_tk0[1]), .lk1_taken(o_tk1[1]), .lk0_idx(o_idx0[1]), .lk1_idx(o_idx1[1]),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .stat_clr(stat_clr),
    .stat_branches(w_sb1), .stat_mispredicts(w_sm1)
  );

  branch_history_table #(.MODE(0), .STAT_W(4)) dut_s4 (
    .clk(clk), .rst(rst), .lk0_pc(lk0_pc), .lk1_pc(lk1_pc),
    .lk0_taken(o_tk0[2]), .lk1_taken(o_tk1[2]), .lk0_idx(o_idx0[2]), .lk1_idx(o_idx1[2]),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .stat_clr(stat_clr),
    .stat_branches(w_sb2), .stat_mispredicts(w_sm2)
  );

  assign o_sb[0] = w_sb0;
  assign o_sm[0] = w_sm0;
  assign o_sb[1] = w_sb1;
  assign o_sm[1] = w_sm1;
  assign o_sb[2] = 32'(w_sb2);
  assign o_sm[2] = 32'(w_sm2);

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic void addv(input logic r, input logic uv, input logic [5:0] ui,
                               input logic ut, input logic um, input logic sc,
                               input logic [31:0] pc0);
    vec_t v;
    v = '{rst: r, uv: uv, ui: ui, ut: ut, um: um, sc: sc, pc0: pc0, hchk: 1'b0,
          hsel: 0, htk0: 1'b0, hidx0: 6'd0, hidx1: 6'd0, hsb: 32'd0, hsm: 32'd0};
    vecs.push_back(v);
  endfunction

  function automatic void hand(input int sel, input logic tk0, input logic [5:0] i0,
                               input logic [5:0] i1, input logic [31:0] sb, input logic [31:0] sm);
    int n;
    n = vecs.size() - 1;
    vecs[n].hchk  = 1'b1;
    vecs[n].hsel  = sel;
    vecs[n].htk0  = tk0;
    vecs[n].hidx0 = i0;
    vecs[n].hidx1 = i1;
    vecs[n].hsb   = sb;
    vecs[n].hsm   = sm;
  endfunction

  function automatic logic [5:0] m_idx(input int d, input logic [31:0] pc);
    logic [5:0] base;
    base = pc[7:2];
    return (d == 1) ? (base ^ mghr[d]) : base;
  endfunction

  // Drive one vector, queue the expected outputs for this cycle, then advance the model.
  task automatic apply(input vec_t v);
    exp_t        e;
    logic [1:0]  c;
    logic [31:0] smax;
    @(posedge clk);
    #1;
    rst = v.rst; upd_valid = v.uv; upd_idx = v.ui; upd_taken = v.ut;
    upd_mispredict = v.um; stat_clr = v.sc; lk0_pc = v.pc0; lk1_pc = PC1;
    e.mval = mvalid;
    for (int d = 0; d < 3; d++) begin
      e.idx0[d] = m_idx(d, v.pc0);
      e.idx1[d] = m_idx(d, PC1);
      e.tk0[d]  = mtab[d][e.idx0[d]][1];
      e.tk1[d]  = mtab[d][e.idx1[d]][1];
      e.sb[d]   = msb[d];
      e.sm[d]   = msm[d];
    end
    e.hchk = v.hchk; e.hsel = v.hsel; e.htk0 = v.htk0;
    e.hidx0 = v.hidx0; e.hidx1 = v.hidx1; e.hsb = v.hsb; e.hsm = v.hsm;
    sb_q.push_back(e);
    for (int d = 0; d < 3; d++) begin
      smax = (d == 2) ? 32'd15 : 32'hFFFF_FFFF;
      if (v.rst) begin
        for (int i = 0; i < 64; i++) mtab[d][i] = 2'b01;
        mghr[d] = 6'd0;
        msb[d]  = 32'd0;
        msm[d]  = 32'd0;
      end else begin
        if (v.uv) begin
          c = mtab[d][v.ui];
          if (v.ut) mtab[d][v.ui] = (c == 2'd3) ? 2'd3 : c + 2'd1;
          else      mtab[d][v.ui] = (c == 2'd0) ? 2'd0 : c - 2'd1;
          mghr[d] = {mghr[d][4:0], v.ut};
        end
        if (v.sc) begin
          msb[d] = 32'd0;
          msm[d] = 32'd0;
        end else if (v.uv) begin
          if (msb[d] != smax) msb[d] = msb[d] + 32'd1;
          if (v.um && msm[d] != smax) msm[d] = msm[d] + 32'd1;
        end
      end
    end
    if (v.rst) mvalid = 1'b1;
  endtask

  // Compare the combinational outputs mid-cycle against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.mval) begin
        for (int d = 0; d < 3; d++) begin
          cmp($sformatf("d%0d_lk0_taken", d), 32'(o_tk0[d]), 32'(e.tk0[d]));
          cmp($sformatf("d%0d_lk1_taken", d), 32'(o_tk1[d]), 32'(e.tk1[d]));
          cmp($sformatf("d%0d_lk0_idx", d), 32'(o_idx0[d]), 32'(e.idx0[d]));
          cmp($sformatf("d%0d_lk1_idx", d), 32'(o_idx1[d]), 32'(e.idx1[d]));
          cmp($sformatf("d%0d_stat_branches", d), o_sb[d], e.sb[d]);
          cmp($sformatf("d%0d_stat_mispredicts", d), o_sm[d], e.sm[d]);
        end
      end
      if (e.hchk) begin
        cmp($sformatf("hand_d%0d_lk0_taken", e.hsel), 32'(o_tk0[e.hsel]), 32'(e.htk0));
        cmp($sformatf("hand_d%0d_lk0_idx", e.hsel), 32'(o_idx0[e.hsel]), 32'(e.hidx0));
        cmp($sformatf("hand_d%0d_lk1_idx", e.hsel), 32'(o_idx1[e.hsel]), 32'(e.hidx1));
        cmp($sformatf("hand_d%0d_branches", e.hsel), o_sb[e.hsel], e.hsb);
        cmp($sformatf("hand_d%0d_mispredicts", e.hsel), o_sm[e.hsel], e.hsm);
      end
    end
  end

  initial begin
    logic [5:0] gpat;
    checks = 0; errors = 0; mvalid = 1'b0;
    rst = 1'b0; upd_valid = 1'b0; upd_idx = 6'd0; upd_taken = 1'b0;
    upd_mispredict = 1'b0; stat_clr = 1'b0; lk0_pc = 32'h100; lk1_pc = PC1;

    // Reset, then saturation on index 0 (bimodal view).
    addv(1, 0, 0, 0, 0, 0, 32'h100);
    addv(0, 0, 0, 0, 0, 0, 32'h100); hand(0, 0, 6'h00, 6'h01, 0, 0);
    addv(0, 1, 0, 1, 0, 0, 32'h100); hand(0, 0, 6'h00, 6'h01, 0, 0);
    addv(0, 1, 0, 1, 0, 0, 32'h100); hand(0, 1, 6'h00, 6'h01, 1, 0);
    addv(0, 1, 0, 1, 0, 0, 32'h100); hand(0, 1, 6'h00, 6'h01, 2, 0);
    addv(0, 1, 0, 0, 1, 0, 32'h100); hand(0, 1, 6'h00, 6'h01, 3, 0);
    addv(0, 1, 0, 0, 1, 0, 32'h100); hand(0, 1, 6'h00, 6'h01, 4, 1);
    addv(0, 1, 0, 0, 0, 0, 32'h100); hand(0, 0, 6'h00, 6'h01, 5, 2);
    addv(0, 1, 0, 0, 0, 0, 32'h100); hand(0, 0, 6'h00, 6'h01, 6, 2);
    addv(0, 0, 0, 0, 0, 0, 32'h100); hand(0, 0, 6'h00, 6'h01, 7, 2);
    // Same-cycle read and write of index 5 returns the old value.
    addv(0, 1, 5, 1, 0, 0, 32'h14);  hand(0, 0, 6'h05, 6'h01, 7, 2);
    addv(0, 0, 0, 0, 0, 0, 32'h14);  hand(0, 1, 6'h05, 6'h01, 8, 2);
    // Statistics: clear, 10 updates with 3 mispredicts, then saturation of the 4-bit copy.
    addv(0, 0, 0, 0, 0, 1, 32'h100); hand(0, 0, 6'h00, 6'h01, 8, 2);
    for (int i = 0; i < 10; i++)
      addv(0, 1, 6'(8 + i), 1'(i % 2), (i == 0 || i == 4 || i == 7), 0, 32'h100);
    addv(0, 0, 0, 0, 0, 0, 32'h100); hand(0, 0, 6'h00, 6'h01, 10, 3);
    for (int i = 0; i < 10; i++)
      addv(0, 1, 6'(20 + i), 1, 0, 0, 32'h100);
    addv(0, 0, 0, 0, 0, 0, 32'h100); hand(2, 0, 6'h00, 6'h01, 15, 3);
    addv(0, 1, 0, 1, 1, 1, 32'h100); hand(0, 0, 6'h00, 6'h01, 20, 3);
    addv(0, 0, 0, 0, 0, 0, 32'h100); hand(0, 0, 6'h00, 6'h01, 0, 0);
    // Gshare: history T,N,T then training under the same and a different history.
    addv(1, 0, 0, 0, 0, 0, 32'h100);
    addv(0, 1, 6'h30, 1, 0, 0, 32'h100);
    addv(0, 1, 6'h30, 0, 0, 0, 32'h100);
    addv(0, 1, 6'h30, 1, 0, 0, 32'h100);
    addv(0, 0, 0, 0, 0, 0, 32'h100); hand(1, 0, 6'h05, 6'h04, 3, 0);
    addv(0, 1, 6'h05, 1, 0, 0, 32'h100);
    addv(0, 1, 6'h05, 1, 0, 0, 32'h100);
    gpat = 6'b000101;
    for (int i = 5; i >= 0; i--)
      addv(0, 1, 6'h30, gpat[i], 0, 0, 32'h100);
    addv(0, 0, 0, 0, 0, 0, 32'h100); hand(1, 1, 6'h05, 6'h04, 11, 0);
    addv(0, 1, 6'h30, 0, 0, 0, 32'h100);
    addv(0, 0, 0, 0, 0, 0, 32'h100); hand(1, 0, 6'h0A, 6'h0B, 12, 0);
    // Reset coincident with an update drops the update and restores initial state.
    addv(0, 1, 0, 1, 0, 0, 32'h100);
    addv(0, 1, 0, 1, 0, 0, 32'h100);
    addv(1, 1, 0, 1, 1, 0, 32'h100); hand(0, 1, 6'h00, 6'h01, 14, 0);
    addv(0, 0, 0, 0, 0, 0, 32'h100); hand(0, 0, 6'h00, 6'h01, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 32'h100); hand(1, 0, 6'h00, 6'h01, 0, 0);

    foreach (vecs[i]) apply(vecs[i]);

    @(posedge clk);
    #1;
    upd_valid = 1'b0; stat_clr = 1'b0; rst = 1'b0;
    @(negedge clk);
    #1;
    cmp("queue_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
